// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler: arbitrates the 8080 LCD byte bus between host command bytes and FMARK-paced frames.
// Optional FMARK watchdog (for panels without TE) is built when LCD_FMARK_TIMEOUT_EN is defined.
module lcd_frame_scheduler #(
   parameter int WIDTH          = 320,
   parameter int HEIGHT         = 240,
   parameter int X_START        = 0,
   parameter int Y_START        = 0,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic        i_lcd_fmark,
   input  logic        i_cmd_valid,
   input  logic        i_cmd_rs,
   input  logic [7:0]  i_cmd_data,
   input  logic        i_cmd_last,
   output logic        o_cmd_ready,
   input  logic        i_pix_valid,
   input  logic [15:0] i_pix_data,
   output logic        o_pix_ready,
   output logic        o_bus_valid,
   output logic        o_bus_rs,
   output logic [7:0]  o_bus_data,
   input  logic        i_bus_ready,
   output logic        o_busy,
   output logic        o_frame_start,
   output logic        o_frame_done,
   output logic        o_frame_late
);
   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int CW = TOTAL > 1 ? $clog2(TOTAL) : 1;
   localparam logic [15:0] XS = 16'(X_START);
   localparam logic [15:0] XE = 16'(X_START + WIDTH - 1);
   localparam logic [15:0] YS = 16'(Y_START);
   localparam logic [15:0] YE = 16'(Y_START + HEIGHT - 1);
   // {rs, data} of the address-window preamble
   localparam logic [8:0] WIN_BYTES [11] = '{
      9'h02A, {1'b1, XS[15:8]}, {1'b1, XS[7:0]}, {1'b1, XE[15:8]}, {1'b1, XE[7:0]},
      9'h02B, {1'b1, YS[15:8]}, {1'b1, YS[7:0]}, {1'b1, YE[15:8]}, {1'b1, YE[7:0]},
      9'h02C
   };

   typedef enum logic [2:0] {IDLE, HOST_REQ, HOST_SEND, WIN, PIX_REQ, PIX_HI, PIX_LO} state_t;

   state_t state;
   logic [2:0] fm_sync;
   logic fm_edge, tmo, can_pend, pending, last_q;
   logic [3:0] idx;
   logic [CW-1:0] cnt;
   logic [7:0] pix_lo;

   assign fm_edge = fm_sync[1] & ~fm_sync[2];
   assign can_pend = state == IDLE || state == HOST_REQ || state == HOST_SEND;

`ifdef LCD_FMARK_TIMEOUT_EN
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tcnt;
   assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1) && !fm_edge;
   always_ff @(posedge i_clk)
      if (i_reset || fm_edge || tmo || !can_pend)
         tcnt <= '0;
      else if (i_enable)
         tcnt <= tcnt + 1'b1;
`else
   // no watchdog: frames start only on FMARK edges
   assign tmo = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= IDLE;
         fm_sync       <= '0;
         pending       <= 1'b0;
         last_q        <= 1'b0;
         idx           <= '0;
         cnt           <= '0;
         pix_lo        <= '0;
         o_cmd_ready   <= 1'b0;
         o_pix_ready   <= 1'b0;
         o_bus_valid   <= 1'b0;
         o_bus_rs      <= 1'b1;
         o_bus_data    <= '0;
         o_busy        <= 1'b0;
         o_frame_start <= 1'b0;
         o_frame_done  <= 1'b0;
         o_frame_late  <= 1'b0;
      end else begin
         fm_sync       <= {fm_sync[1:0], i_lcd_fmark};
         o_frame_start <= 1'b0;
         o_frame_done  <= 1'b0;
         o_frame_late  <= fm_edge && (pending || !can_pend);
         if ((fm_edge || tmo) && i_enable && can_pend)
            pending <= 1'b1;
         case (state)
            IDLE:
               if (pending) begin
                  state         <= WIN;
                  pending       <= 1'b0;
                  idx           <= '0;
                  o_frame_start <= 1'b1;
                  o_busy        <= 1'b1;
                  o_bus_valid   <= 1'b1;
                  {o_bus_rs, o_bus_data} <= WIN_BYTES[0];
               end else if (i_cmd_valid) begin
                  state       <= HOST_REQ;
                  o_busy      <= 1'b1;
                  o_cmd_ready <= 1'b1;
               end
            HOST_REQ:
               if (i_cmd_valid) begin
                  state       <= HOST_SEND;
                  o_cmd_ready <= 1'b0;
                  last_q      <= i_cmd_last;
                  o_bus_valid <= 1'b1;
                  o_bus_rs    <= i_cmd_rs;
                  o_bus_data  <= i_cmd_data;
               end
            HOST_SEND:
               if (i_bus_ready) begin
                  state       <= last_q ? IDLE : HOST_REQ;
                  o_bus_valid <= 1'b0;
                  o_cmd_ready <= !last_q;
                  o_busy      <= !last_q;
               end
            WIN:
               if (i_bus_ready) begin
                  if (idx == 4'd10) begin
                     state       <= PIX_REQ;
                     o_bus_valid <= 1'b0;
                     o_pix_ready <= 1'b1;
                     cnt         <= CW'(TOTAL - 1);
                  end else begin
                     idx <= idx + 4'd1;
                     {o_bus_rs, o_bus_data} <= WIN_BYTES[idx + 4'd1];
                  end
               end
            PIX_REQ:
               if (i_pix_valid) begin
                  state       <= PIX_HI;
                  o_pix_ready <= 1'b0;
                  pix_lo      <= i_pix_data[7:0];
                  o_bus_valid <= 1'b1;
                  o_bus_rs    <= 1'b1;
                  o_bus_data  <= i_pix_data[15:8];
               end
            PIX_HI:
               if (i_bus_ready) begin
                  state      <= PIX_LO;
                  o_bus_data <= pix_lo;
               end
            PIX_LO:
               if (i_bus_ready) begin
                  o_bus_valid <= 1'b0;
                  if (cnt == '0) begin
                     state        <= IDLE;
                     o_busy       <= 1'b0;
                     o_frame_done <= 1'b1;
                  end else begin
                     state       <= PIX_REQ;
                     cnt         <= cnt - 1'b1;
                     o_pix_ready <= 1'b1;
                  end
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb_lcd_frame_scheduler: directed vectors for a 4x2 window at (0x123, 0xEE), TIMEOUT_CYCLES=100.
module tb_lcd_frame_scheduler;
   typedef struct {
      logic [15:0] pix;
      logic [8:0]  hi;
      logic [8:0]  lo;
   } pix_vec_t;

   logic clk = 1'b0, reset = 1'b1, enable = 1'b0, fmark = 1'b0;
   logic cmd_valid = 1'b0, cmd_rs = 1'b0, cmd_last = 1'b0, cmd_ready;
   logic [7:0] cmd_data = '0;
   logic pix_valid = 1'b0, pix_ready;
   logic [15:0] pix_data = '0;
   logic bus_valid, bus_rs, bus_ready = 1'b0;
   logic [7:0] bus_data;
   logic busy, frame_start, frame_done, frame_late;

   pix_vec_t pv [8];
   logic [8:0] win_exp [11];
   logic [8:0] exp_bytes [27];
   logic [8:0] cap [$];
   int checks = 0, errors = 0;
   int n_start = 0, n_done = 0, n_late = 0, pix_n = 0;
   bit pix_hs = 1'b0;

   always #5 clk = ~clk;

   lcd_frame_scheduler #(
      .WIDTH(4), .HEIGHT(2), .X_START('h123), .Y_START('hEE), .TIMEOUT_CYCLES(100)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_lcd_fmark(fmark),
      .i_cmd_valid(cmd_valid), .i_cmd_rs(cmd_rs), .i_cmd_data(cmd_data),
      .i_cmd_last(cmd_last), .o_cmd_ready(cmd_ready),
      .i_pix_valid(pix_valid), .i_pix_data(pix_data), .o_pix_ready(pix_ready),
      .o_bus_valid(bus_valid), .o_bus_rs(bus_rs), .o_bus_data(bus_data),
      .i_bus_ready(bus_ready), .o_busy(busy), .o_frame_start(frame_start),
      .o_frame_done(frame_done), .o_frame_late(frame_late)
   );

   // mid-cycle monitor: records each handshake that the coming edge completes
   always @(negedge clk) begin
      if (pix_hs) pix_n++;
      pix_hs = pix_valid && pix_ready && !reset;
      pix_data = pv[pix_n % 8].pix;
      if (!reset) begin
         if (bus_valid && bus_ready) cap.push_back({bus_rs, bus_data});
         if (frame_start) n_start++;
         if (frame_done) n_done++;
         if (frame_late) n_late++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats;
      cap.delete();
      n_start = 0;
      n_done = 0;
      n_late = 0;
   endtask

   task automatic start_frame(output int lat);
      lat = 0;
      fmark = 1'b1;
      while (!frame_start && lat < 20) begin
         tick(1);
         lat++;
      end
      fmark = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget, input int len);
      int c = 0;
      while (!frame_done && c < budget) begin
         tick(1);
         c++;
      end
      chk({nm, "_done_seen"}, 32'(frame_done), 32'd1);
      chk({nm, "_len"}, 32'(cap.size()), 32'(len));
   endtask

   task automatic check_stream(input string nm, input int off);
      for (int i = 0; i < 27; i++)
         chk($sformatf("%s_byte%0d", nm, i), 32'(cap[off + i]), 32'(exp_bytes[i]));
   endtask

   task automatic host_byte(input logic rs, input logic [7:0] d, input logic last);
      int c = 0;
      cmd_valid = 1'b1;
      cmd_rs = rs;
      cmd_data = d;
      cmd_last = last;
      while (!cmd_ready && c < 20) begin
         tick(1);
         c++;
      end
      chk("host_ready_seen", 32'(cmd_ready), 32'd1);
      tick(1);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_cap(input int n);
      int c = 0;
      while (cap.size() < n && c < 100) begin
         tick(1);
         c++;
      end
      chk("wait_cap", 32'(cap.size() >= n), 32'd1);
   endtask

   initial begin
      int lat, c;
      pv = '{
         '{16'h1234, 9'h112, 9'h134}, '{16'h5678, 9'h156, 9'h178},
         '{16'h9ABC, 9'h19A, 9'h1BC}, '{16'hDEF0, 9'h1DE, 9'h1F0},
         '{16'h0F1E, 9'h10F, 9'h11E}, '{16'h2D3C, 9'h12D, 9'h13C},
         '{16'h4B5A, 9'h14B, 9'h15A}, '{16'h6978, 9'h169, 9'h178}
      };
      win_exp = '{9'h02A, 9'h101, 9'h123, 9'h101, 9'h126,
                  9'h02B, 9'h100, 9'h1EE, 9'h100, 9'h1EF, 9'h02C};
      for (int i = 0; i < 11; i++) exp_bytes[i] = win_exp[i];
      for (int i = 0; i < 8; i++) begin
         exp_bytes[11 + 2 * i] = pv[i].hi;
         exp_bytes[12 + 2 * i] = pv[i].lo;
      end

      tick(3);
      chk("reset_outputs",
          32'({bus_valid, bus_rs, bus_data, cmd_ready, pix_ready, busy, frame_start, frame_done, frame_late}),
          32'h0000_4000);
      reset = 1'b0;
      enable = 1'b1;
      bus_ready = 1'b1;
      pix_valid = 1'b1;
      tick(2);

      // plain frame
      clear_stats();
      start_frame(lat);
      chk("start_latency", 32'(lat >= 3 && lat <= 4), 32'd1);
      wait_done("frame1", 100, 27);
      check_stream("frame1", 0);
      tick(3);
      chk("frame1_start_cnt", 32'(n_start), 32'd1);
      chk("frame1_done_cnt", 32'(n_done), 32'd1);
      chk("frame1_idle", 32'(busy), 32'd0);

      // host sequence in flight when FMARK arrives
      clear_stats();
      fmark = 1'b1;
      host_byte(1'b0, 8'h36, 1'b0);
      host_byte(1'b1, 8'h48, 1'b1);
      fmark = 1'b0;
      wait_done("frame2", 150, 29);
      chk("host_byte0", 32'(cap[0]), 32'h036);
      chk("host_byte1", 32'(cap[1]), 32'h148);
      check_stream("frame2", 2);
      tick(3);
      chk("frame2_start_cnt", 32'(n_start), 32'd1);

      // FMARK while streaming pixels
      clear_stats();
      start_frame(lat);
      tick(15);
      fmark = 1'b1;
      tick(4);
      fmark = 1'b0;
      wait_done("frame3", 100, 27);
      tick(20);
      chk("late_cnt", 32'(n_late), 32'd1);
      chk("late_no_second_frame", 32'(n_start), 32'd1);
      chk("late_done_cnt", 32'(n_done), 32'd1);
      chk("late_idle", 32'(busy), 32'd0);

      // bus stall mid-window
      clear_stats();
      start_frame(lat);
      wait_cap(3);
      bus_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk($sformatf("stall_hold%0d", i), 32'({bus_valid, bus_rs, bus_data}), 32'({1'b1, exp_bytes[3]}));
      end
      bus_ready = 1'b1;
      wait_done("frame4", 100, 27);
      check_stream("frame4", 0);

      // reset mid-pixel
      tick(3);
      clear_stats();
      start_frame(lat);
      wait_cap(14);
      reset = 1'b1;
      tick(1);
      chk("rst_bus_valid", 32'(bus_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pix_ready", 32'(pix_ready), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(30);
      chk("rst_no_done", 32'(n_done), 32'd0);
      chk("rst_idle", 32'(busy), 32'd0);
      chk("rst_no_restart", 32'(n_start), 32'd1);

      // FMARK tied low
      reset = 1'b1;
      enable = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(2);
      clear_stats();
      enable = 1'b1;
      c = 0;
      while (!frame_start && c < 300) begin
         tick(1);
         c++;
      end
`ifdef LCD_FMARK_TIMEOUT_EN
      chk("timeout_start", 32'(c >= 99 && c <= 102), 32'd1);
      wait_done("frame_tmo", 100, 27);
`else
      chk("no_frame_without_fmark", 32'(n_start), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
